roce_uart_rx_parser: RTL
========================

// Module: roce_uart_rx_parser
// PURPOSE
//  Receive end of the RoCEv2-over-UART link. Deserialises 8N1 bytes on uart_rx and
//  parses the fixed frame: version, opcode, qp[15:0], psn[31:0], PAYLOAD_LEN payload bytes.
//  Multi-byte fields are MSB first. Payload goes to a 256x8 buffer with a read port.
//  Header fields are published with a one-cycle pkt_valid pulse.
// PARAMETERS
//  BAUD_DIV      234    clk cycles per UART bit
//  PAYLOAD_LEN   11     payload bytes per frame, 1..248; frame = 8+PAYLOAD_LEN bytes
//  EXP_VERSION   8'h02  required value of byte 0
//  IDLE_TIMEOUT  4096   clk cycles with no byte before a partial frame is dropped
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-high reset
//  uart_rx    in   1   serial input, idle high, asynchronous to clk
//  rd_addr    in   8   payload buffer read address
//  rd_data    out  8   mem[rd_addr], registered, 1-cycle latency
//  pkt_valid  out  1   1-cycle pulse: complete, valid frame received
//  opcode     out  8   opcode of the last valid frame
//  qp         out  16  queue pair of the last valid frame
//  psn        out  32  packet sequence number of the last valid frame
//  busy       out  1   1 while a frame is partially received (byte_idx!=0 or DROP)
//  err_version out 1   1-cycle pulse: byte 0 != EXP_VERSION
//  err_frame  out  1   1-cycle pulse: stop bit sampled 0
//  err_timeout out 1   1-cycle pulse: partial frame aborted by idle timeout
//  err_psn    out  1   1-cycle pulse: PSN sequence break (see CONFIGURATION)
// BEHAVIOUR
//  Reset: every output 0; uart_rx synchroniser flops = 1; FSMs in IDLE/HDR with byte_idx=0.
//   Buffer contents are not cleared. Reset mid-frame discards the frame and raises no error pulse.
//  Sync: uart_rx passes through 2 flops; all sampling uses the synchronised value.
//  Bit FSM IDLE->START->DATA->STOP:
//   - IDLE: a low level starts a count of BAUD_DIV/2 cycles; resample.
//     If the resample is high, treat it as a glitch and return to IDLE; no pulse.
//   - DATA: 8 bits, LSB first, each sampled BAUD_DIV cycles after the previous one.
//   - STOP: sample 1 -> byte_valid for 1 cycle. Sample 0 -> err_frame pulse, the parser
//     aborts to byte_idx=0, and the bit FSM waits for the line to be high before IDLE.
//  Parser (acts on byte_valid), byte_idx 0..7+PAYLOAD_LEN:
//   - idx0: compare with EXP_VERSION. Mismatch -> err_version, enter DROP.
//   - idx1 opcode, idx2-3 qp, idx4-7 psn: captured into shadow registers only.
//   - idx>=8: mem[idx-8] <= byte, written on the byte_valid cycle.
//   - Last byte: the next cycle, pkt_valid=1 and opcode/qp/psn <= shadows.
//     Outputs hold until the next valid frame; byte_idx returns to 0.
//   - DROP: consumes bytes without writing. It leaves only on idle timeout,
//     silently, with no err_timeout pulse.
//  Timeout counter:
//   - Cleared on every byte_valid; counts while busy.
//   - Reaching IDLE_TIMEOUT in HDR/PAYLOAD -> err_timeout, byte_idx=0.
//  Aborted frames: payload bytes already written stay in the buffer;
//   opcode/qp/psn are unchanged; no pkt_valid.
//  Read port: a read of the address being written in the same cycle returns the old data.
//  Error pulses and pkt_valid are mutually exclusive, except err_psn, which coincides
//   with pkt_valid.
// CONFIGURATION
//  PSN_CHECK_EN defined:
//   - Keep exp_psn plus a seen flag (both 0 at reset).
//   - On each pkt_valid with seen=1 and psn != exp_psn: pulse err_psn. pkt_valid still asserts.
//   - Every valid frame sets exp_psn <= psn+1 (32-bit wrap) and seen <= 1.
//  PSN_CHECK_EN undefined: err_psn tied 0; no PSN state is built.
// TESTING
//  1 Frame 02 01 00 7B 00 00 01 C8 "Hello RDMA!" at BAUD_DIV=234 ->
//    one pkt_valid, opcode=01, qp=007B, psn=000001C8, rd_addr 0..10 reads "Hello RDMA!".
//  2 Same frame with byte0=03 -> err_version, no pkt_valid, fields hold the test-1 values,
//    buffer unchanged; after IDLE_TIMEOUT idle, a good frame is accepted.
//  3 Stop bit of byte 5 forced 0 -> err_frame; the following good frame gives pkt_valid.
//  4 First 10 bytes only, then idle -> err_timeout exactly IDLE_TIMEOUT cycles after byte 10;
//    busy drops.
//  5 50-cycle low glitch on uart_rx -> no byte_valid, busy stays 0.
//    rst asserted mid-payload -> all outputs 0; a subsequent frame parses.
//  6 PSN_CHECK_EN: psn 1C8 then 1CA -> err_psn on the 2nd pkt_valid.
//    Then 1CB -> none. Then FFFFFFFF followed by 00000000 -> none (wrap).

Source files
------------

// File: rtl/roce_uart_rx_parser.sv
// -----------------------------------------------------------------------------
// roce_uart_rx_parser
//
// Receive end of the RoCEv2-over-UART link. 8N1 bytes arriving on uart_rx are
// deserialised and parsed as a fixed frame:
//   byte 0        version (must equal EXP_VERSION)
//   byte 1        opcode
//   bytes 2-3     queue pair, MSB first
//   bytes 4-7     packet sequence number, MSB first
//   bytes 8..     PAYLOAD_LEN payload bytes, stored in a 256x8 buffer
// When the last payload byte arrives, the header fields are published and
// pkt_valid pulses for one cycle.
//
// Optional feature: define PSN_CHECK_EN to build the PSN sequence checker
// (err_psn). With the macro undefined, err_psn is tied low and no PSN state
// exists.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   uart_rx      serial input, idle high, asynchronous to clk
//   rd_addr      payload buffer read address
//   rd_data      mem[rd_addr], registered, one cycle of latency
//   pkt_valid    one-cycle pulse: complete valid frame received
//   opcode       opcode of the last valid frame
//   qp           queue pair of the last valid frame
//   psn          packet sequence number of the last valid frame
//   busy         high while a frame is partially received or being dropped
//   err_version  one-cycle pulse: byte 0 did not match EXP_VERSION
//   err_frame    one-cycle pulse: stop bit sampled low
//   err_timeout  one-cycle pulse: partial frame aborted by idle timeout
//   err_psn      one-cycle pulse with pkt_valid: PSN sequence break
// -----------------------------------------------------------------------------
module roce_uart_rx_parser #(
  parameter int         BAUD_DIV     = 234,
  parameter int         PAYLOAD_LEN  = 11,
  parameter logic [7:0] EXP_VERSION  = 8'h02,
  parameter int         IDLE_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  input  logic [7:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        pkt_valid,
  output logic [7:0]  opcode,
  output logic [15:0] qp,
  output logic [31:0] psn,
  output logic        busy,
  output logic        err_version,
  output logic        err_frame,
  output logic        err_timeout,
  output logic        err_psn
);

  localparam int             BW       = $clog2(BAUD_DIV + 1);
  localparam logic [BW-1:0]  HALF_M1  = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0]  FULL_M1  = BW'(BAUD_DIV - 1);
  localparam int             TW       = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0]  TO_M1    = TW'(IDLE_TIMEOUT - 1);
  localparam logic [7:0]     LAST_IDX = 8'(7 + PAYLOAD_LEN);

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP,
    B_WAIT_HIGH
  } bit_state_t;

  typedef enum logic [1:0] {
    P_HDR,
    P_PAYLOAD,
    P_DROP
  } parse_state_t;

  // Synchroniser
  logic rx_meta;
  logic rx_sync;

  // Bit-level receiver
  bit_state_t    bstate;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          frame_err;

  // Frame parser
  parse_state_t  pstate;
  logic [7:0]    byte_idx;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    sh_op;
  logic [15:0]   sh_qp;
  logic [31:0]   sh_psn;

  // Payload buffer
  logic [7:0]    mem [0:255];
  logic          wr_en;
  logic [7:0]    wr_addr;
  logic          frame_done;

  // uart_rx is asynchronous to clk; two flops bring it into the clock domain.
  // They reset high so the idle line is not mistaken for a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // 8N1 bit receiver. A falling edge is confirmed half a bit later, which
  // also places every subsequent sample in the middle of its bit. A low stop
  // bit is reported and the receiver then waits for the line to return high,
  // so that a held-low line does not produce a stream of phantom bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bstate     <= B_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (bstate)
        B_IDLE: begin
          baud_cnt <= '0;
          if (!rx_sync) begin
            bstate <= B_START;
          end
        end
        B_START: begin
          if (baud_cnt == HALF_M1) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            bstate   <= rx_sync ? B_IDLE : B_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt <= '0;
            rx_byte  <= {rx_sync, rx_byte[7:1]};
            if (bit_cnt == 3'd7) begin
              bstate <= B_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        B_STOP: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt <= '0;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              bstate     <= B_IDLE;
            end else begin
              frame_err <= 1'b1;
              bstate    <= B_WAIT_HIGH;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        B_WAIT_HIGH: begin
          baud_cnt <= '0;
          if (rx_sync) begin
            bstate <= B_IDLE;
          end
        end
        default: begin
          bstate <= B_IDLE;
        end
      endcase
    end
  end

  // busy covers both a partially received frame and a frame being dropped
  // after a version mismatch (which sits at byte_idx 0).
  assign busy = (byte_idx != 8'd0) || (pstate == P_DROP);

  assign wr_en      = byte_valid && (pstate == P_PAYLOAD);
  assign wr_addr    = byte_idx - 8'd8;
  assign frame_done = wr_en && (byte_idx == LAST_IDX);

  // Frame parser. Header fields go into shadow registers so that an aborted
  // frame never disturbs the published opcode/qp/psn. A dropped frame is only
  // left through the idle timeout, because its length cannot be trusted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate      <= P_HDR;
      byte_idx    <= '0;
      idle_cnt    <= '0;
      sh_op       <= '0;
      sh_qp       <= '0;
      sh_psn      <= '0;
      opcode      <= '0;
      qp          <= '0;
      psn         <= '0;
      pkt_valid   <= 1'b0;
      err_version <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      pkt_valid   <= 1'b0;
      err_version <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      if (frame_err) begin
        err_frame <= 1'b1;
        if (pstate != P_DROP) begin
          pstate   <= P_HDR;
          byte_idx <= '0;
          idle_cnt <= '0;
        end
      end else if (byte_valid) begin
        idle_cnt <= '0;
        case (pstate)
          P_HDR: begin
            if (byte_idx == 8'd0) begin
              if (rx_byte != EXP_VERSION) begin
                err_version <= 1'b1;
                pstate      <= P_DROP;
              end else begin
                byte_idx <= 8'd1;
              end
            end else begin
              if (byte_idx == 8'd1) begin
                sh_op <= rx_byte;
              end else if (byte_idx <= 8'd3) begin
                sh_qp <= {sh_qp[7:0], rx_byte};
              end else begin
                sh_psn <= {sh_psn[23:0], rx_byte};
              end
              byte_idx <= byte_idx + 8'd1;
              if (byte_idx == 8'd7) begin
                pstate <= P_PAYLOAD;
              end
            end
          end
          P_PAYLOAD: begin
            if (byte_idx == LAST_IDX) begin
              pkt_valid <= 1'b1;
              opcode    <= sh_op;
              qp        <= sh_qp;
              psn       <= sh_psn;
              byte_idx  <= '0;
              pstate    <= P_HDR;
            end else begin
              byte_idx <= byte_idx + 8'd1;
            end
          end
          default: begin
            // P_DROP: bytes are swallowed; only the timer reset above applies
          end
        endcase
      end else if (busy) begin
        if (idle_cnt == TO_M1) begin
          idle_cnt <= '0;
          byte_idx <= '0;
          pstate   <= P_HDR;
          if (pstate != P_DROP) begin
            err_timeout <= 1'b1;
          end
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

  // Payload buffer. No reset, so contents survive reset and aborted frames.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= rx_byte;
    end
  end

  // Registered read port; a read of the address written in the same cycle
  // returns the previous contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

`ifdef PSN_CHECK_EN
  // PSN sequence checker: every valid frame should carry the previous PSN
  // plus one (32-bit wrap). The first frame after reset only seeds it.
  logic [31:0] exp_psn;
  logic        seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_psn <= '0;
      seen    <= 1'b0;
      err_psn <= 1'b0;
    end else begin
      err_psn <= 1'b0;
      if (frame_done) begin
        err_psn <= seen && (sh_psn != exp_psn);
        exp_psn <= sh_psn + 32'd1;
        seen    <= 1'b1;
      end
    end
  end
`else
  assign err_psn = 1'b0;
`endif

endmodule
